lzs_bit_unpacker: RTL

Synthesizable bit-stream unpacker for the LZS decode path. It accepts fixed-width big-endian words from an upstream word source and presents a left-aligned window of the oldest unconsumed bits to the decoder on the `stream_data`/`stream_ack`/`stream_width` interface. Each accepted handshake consumes a variable number of bits. It also replaces the behavioural stream feeder with a parametrised RTL block that tracks length, zero-pads the tail, and signals end of stream.

---
 rtl/lzs_bit_unpacker.sv | 127 ++++++++++++
 1 files changed

// File: rtl/lzs_bit_unpacker.sv
// LZS bit-stream unpacker: big-endian words in, left-aligned window of the
// oldest unconsumed bits out, variable-width consume per handshake.
module lzs_bit_unpacker #(
   parameter int IN_WORD    = 16,
   parameter int OUT_WIDTH  = 13,
   parameter int BUF_WIDTH  = 64,
   parameter int WIDTH_BITS = 4,
   parameter int LEN_WIDTH  = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  src_len,
   input  logic                  word_valid,
   input  logic [IN_WORD-1:0]    word_data,
   output logic                  word_ready,
   output logic                  stream_valid,
   output logic [OUT_WIDTH-1:0]  stream_data,
   input  logic                  stream_ack,
   input  logic [WIDTH_BITS-1:0] stream_width,
   output logic                  stream_empty,
   output logic                  busy
);

   localparam int LW       = $clog2(BUF_WIDTH + 1);
   localparam int CW       = (LW > WIDTH_BITS) ? LW : WIDTH_BITS;
   localparam int IN_BYTES = IN_WORD / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state, state_n;
   logic [BUF_WIDTH-1:0] bit_buf, bit_buf_n;
   logic [LW-1:0]        left, left_n;
   logic [LEN_WIDTH-1:0] words_rem, words_rem_n;
   logic                 empty_q, empty_n;

   logic                 accept, consume;
   logic [CW-1:0]        width_ext, w, left_ext, left_sh_ext;
   logic [LW-1:0]        left_mid;
   logic [BUF_WIDTH-1:0] buf_mid, word_pos;
   logic [LEN_WIDTH:0]   len_round;
   logic [LEN_WIDTH-1:0] words_load;

   // Outputs decoded from registered state only
   assign busy         = (state == RUN);
   assign word_ready   = busy && (words_rem != '0) && (left <= LW'(BUF_WIDTH - IN_WORD));
   assign stream_valid = busy && ((left >= LW'(OUT_WIDTH)) || ((words_rem == '0) && (left != '0)));
   assign stream_data  = bit_buf[BUF_WIDTH-1 -: OUT_WIDTH];
   assign stream_empty = empty_q;

   // Datapath: clamp the consume width, shift first, then place the new word at the post-shift fill level
   always_comb begin
      accept    = word_valid && word_ready;
      consume   = stream_ack && stream_valid;
      width_ext = CW'(stream_width);
      w         = (width_ext > CW'(OUT_WIDTH)) ? CW'(OUT_WIDTH) : width_ext;
      left_ext  = CW'(left);
      left_sh_ext = (left_ext > w) ? (left_ext - w) : '0;
      buf_mid   = consume ? (bit_buf << w) : bit_buf;
      left_mid  = consume ? LW'(left_sh_ext) : left;
      word_pos  = {word_data, {(BUF_WIDTH-IN_WORD){1'b0}}} >> left_mid;
      len_round = {1'b0, src_len} + (LEN_WIDTH+1)'(IN_BYTES - 1);
      words_load = LEN_WIDTH'(len_round / (LEN_WIDTH+1)'(IN_BYTES));
   end

   // Next-state and register-update decode
   always_comb begin
      state_n     = state;
      bit_buf_n   = bit_buf;
      left_n      = left;
      words_rem_n = words_rem;
      empty_n     = empty_q;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               bit_buf_n   = '0;
               left_n      = '0;
               words_rem_n = words_load;
               if (src_len == '0) begin
                  state_n = DONE;
                  empty_n = 1'b1;
               end else begin
                  state_n = RUN;
                  empty_n = 1'b0;
               end
            end
         end
         RUN: begin
            if ((words_rem == '0) && (left == '0)) begin
               state_n = DONE;
               empty_n = 1'b1;
            end else begin
               bit_buf_n = buf_mid;
               left_n    = left_mid;
               if (accept) begin
                  bit_buf_n   = buf_mid | word_pos;
                  left_n      = left_mid + LW'(IN_WORD);
                  words_rem_n = words_rem - 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_buf   <= '0;
         left      <= '0;
         words_rem <= '0;
         empty_q   <= 1'b0;
      end else begin
         state     <= state_n;
         bit_buf   <= bit_buf_n;
         left      <= left_n;
         words_rem <= words_rem_n;
         empty_q   <= empty_n;
      end
   end

endmodule
